// File: rtl/huffman_chunk_encoder_if.sv
// huffman_chunk_encoder_if: pixel stream input, RAM write port and frame status.
// The slave modport is the encoder; the master modport is the pixel source / RAM side.
interface huffman_chunk_encoder_if #(
   parameter int ADDR_W = 16
);

   logic              pixel_write_valid;
   logic              pixel_ready;
   logic [31:0]       color;
   logic              frame_end;
   logic [ADDR_W-1:0] RAM_address;
   logic [31:0]       RAM_writedata;
   logic              RAM_write;
   logic              RAM_waitrequest;
   logic              done;
   logic [ADDR_W-1:0] word_count;
   logic              overflow;

   modport master (
      output pixel_write_valid,
      output color,
      output frame_end,
      output RAM_waitrequest,
      input  pixel_ready,
      input  RAM_address,
      input  RAM_writedata,
      input  RAM_write,
      input  done,
      input  word_count,
      input  overflow
   );

   modport slave (
      input  pixel_write_valid,
      input  color,
      input  frame_end,
      input  RAM_waitrequest,
      output pixel_ready,
      output RAM_address,
      output RAM_writedata,
      output RAM_write,
      output done,
      output word_count,
      output overflow
   );

endinterface

// File: rtl/huffman_chunk_encoder.sv
// huffman_chunk_encoder: each pixel becomes '0' (repeat of the previous pixel) or
// '1' + 24 RGB bits, packed LSB-first into a 64-bit accumulator and written to RAM
// as 32-bit words. frame_end flushes the partial word and pulses done.
module huffman_chunk_encoder #(
   parameter int ADDR_W = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   huffman_chunk_encoder_if.slave bus
);

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      FLUSH = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t state;
   state_t state_nxt;

   // packing state: bits above fill_p0 in acc_p0 are always zero, so a partial
   // flush word comes out zero-padded without extra masking
   logic [63:0]       acc_p0;
   logic [5:0]        fill_p0;
   logic [23:0]       prev_p0;
   logic [ADDR_W-1:0] addr_p0;
   logic [ADDR_W-1:0] word_count_q;
   logic              overflow_q;
   logic              new_frame_q;

   logic              pix_ready;
   logic              wr_req;
   logic              done_o;
   logic              vld_p0;
   logic              wr_done;
   logic [24:0]       code_p0;
   logic [5:0]        code_len_p0;

   function automatic logic [24:0] pixel_code(input logic [23:0] pix,
                                              input logic [23:0] prev);
      if (pix == prev) begin
         return 25'd0;
      end
      return {pix, 1'b1};
   endfunction

   function automatic logic [5:0] pixel_code_len(input logic [23:0] pix,
                                                 input logic [23:0] prev);
      return (pix == prev) ? 6'd1 : 6'd25;
   endfunction

   // p0: code of the offered pixel against the previous one
   assign code_p0     = pixel_code(bus.color[23:0], prev_p0);
   assign code_len_p0 = pixel_code_len(bus.color[23:0], prev_p0);
   assign vld_p0      = pix_ready && bus.pixel_write_valid;
   assign wr_done     = wr_req && !bus.RAM_waitrequest;

   // state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= RUN;
      end else begin
         state <= state_nxt;
      end
   end

   // next state: flush finishes once the accumulator drains (or was already empty)
   always_comb begin
      state_nxt = state;
      case (state)
         RUN: begin
            if (bus.frame_end) begin
               state_nxt = FLUSH;
            end
         end
         FLUSH: begin
            if ((fill_p0 == 6'd0) || (wr_done && (fill_p0 <= 6'd32))) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            state_nxt = RUN;
         end
         default: begin
            state_nxt = RUN;
         end
      endcase
   end

   // outputs: accept only while less than a word is buffered, so fill never exceeds 56
   always_comb begin
      pix_ready = (state == RUN) && (fill_p0 < 6'd32);
      wr_req    = ((state == RUN) && (fill_p0 >= 6'd32)) ||
                  ((state == FLUSH) && (fill_p0 != 6'd0));
      done_o    = (state == DONE);
   end

   // datapath: write completion and pixel acceptance are mutually exclusive by fill
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_p0       <= '0;
         fill_p0      <= '0;
         prev_p0      <= '0;
         addr_p0      <= '0;
         word_count_q <= '0;
         overflow_q   <= 1'b0;
         new_frame_q  <= 1'b0;
      end else if (state == DONE) begin
         acc_p0      <= '0;
         fill_p0     <= '0;
         prev_p0     <= '0;
         addr_p0     <= '0;
         new_frame_q <= 1'b1;
      end else if (wr_done) begin
         acc_p0       <= {32'd0, acc_p0[63:32]};
         fill_p0      <= (fill_p0 >= 6'd32) ? (fill_p0 - 6'd32) : 6'd0;
         addr_p0      <= addr_p0 + ADDR_W'(1);
         word_count_q <= new_frame_q ? ADDR_W'(1) : (word_count_q + ADDR_W'(1));
         new_frame_q  <= 1'b0;
         if (addr_p0 == '1) begin
            overflow_q <= 1'b1;
         end
      end else if (vld_p0) begin
         acc_p0  <= acc_p0 | (64'(code_p0) << fill_p0);
         fill_p0 <= fill_p0 + code_len_p0;
         prev_p0 <= bus.color[23:0];
      end
   end

   assign bus.pixel_ready   = pix_ready;
   assign bus.RAM_address   = addr_p0;
   assign bus.RAM_writedata = acc_p0[31:0];
   assign bus.RAM_write     = wr_req;
   assign bus.done          = done_o;
   assign bus.word_count    = word_count_q;
   assign bus.overflow      = overflow_q;

endmodule

// File: tb/tb_huffman_chunk_encoder.sv
// tb_huffman_chunk_encoder: two encoders (ADDR_W 16 and 4) share one stimulus.
// A bit-queue model of the code stream is compared against both every cycle;
// directed frames pin the model with hand-computed words.
module tb_huffman_chunk_encoder;

   localparam int RUN   = 0;
   localparam int FLUSH = 1;
   localparam int DONE  = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        pvalid = 1'b0;
   logic [31:0] color = 32'd0;
   logic        fe = 1'b0;
   logic        wreq = 1'b0;

   huffman_chunk_encoder_if #(.ADDR_W(16)) bus_a ();
   huffman_chunk_encoder_if #(.ADDR_W(4))  bus_b ();

   huffman_chunk_encoder #(.ADDR_W(16)) dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
   huffman_chunk_encoder #(.ADDR_W(4))  dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

   assign bus_a.pixel_write_valid = pvalid;
   assign bus_a.color             = color;
   assign bus_a.frame_end         = fe;
   assign bus_a.RAM_waitrequest   = wreq;
   assign bus_b.pixel_write_valid = pvalid;
   assign bus_b.color             = color;
   assign bus_b.frame_end         = fe;
   assign bus_b.RAM_waitrequest   = wreq;

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   int          m_phase = RUN;
   bit          m_q[$];
   logic [23:0] m_prev = 24'd0;
   int          m_addr = 0;
   int          m_wc = 0;
   bit          m_nf = 1'b0;
   bit          m_ovf16 = 1'b0;
   bit          m_ovf4 = 1'b0;
   bit          chk_on = 1'b0;

   // sampled DUT activity for the directed part
   bit          rdy_s = 1'b0;
   int          done_cnt = 0;
   logic [31:0] cap_d[$];
   int          cap_ad[$];
   int          cap_ad4[$];

   task automatic model_reset();
      m_phase = RUN;
      m_q.delete();
      m_prev  = 24'd0;
      m_addr  = 0;
      m_wc    = 0;
      m_nf    = 1'b0;
      m_ovf16 = 1'b0;
      m_ovf4  = 1'b0;
   endtask

   task automatic model_push(input logic [23:0] p);
      if (p == m_prev) begin
         m_q.push_back(1'b0);
      end else begin
         m_q.push_back(1'b1);
         for (int b = 0; b < 24; b++) m_q.push_back(p[b]);
      end
      m_prev = p;
   endtask

   task automatic model_write_done();
      int n;
      n = (m_q.size() >= 32) ? 32 : m_q.size();
      for (int i = 0; i < n; i++) void'(m_q.pop_front());
      if ((m_addr % 16) == 15)    m_ovf4 = 1'b1;
      if ((m_addr % 65536) == 65535) m_ovf16 = 1'b1;
      m_addr++;
      m_wc = m_nf ? 1 : m_wc + 1;
      m_nf = 1'b0;
   endtask

   task automatic cmp_inst(input string tag, input int aw,
                           input logic rdy, input logic wr, input logic dn,
                           input logic [31:0] wc, input logic ovf,
                           input logic [31:0] addr, input logic [31:0] data,
                           input bit xr, input bit xw, input logic [31:0] xd, input bit xovf);
      int md;
      md = 1 << aw;
      check({tag, "_ready"}, 32'(rdy), 32'(xr));
      check({tag, "_write"}, 32'(wr), 32'(xw));
      check({tag, "_done"}, 32'(dn), 32'(m_phase == DONE));
      check({tag, "_word_count"}, wc, 32'(m_wc % md));
      check({tag, "_overflow"}, 32'(ovf), 32'(xovf));
      if (xw) begin
         check({tag, "_addr"}, addr, 32'(m_addr % md));
         check({tag, "_data"}, data, xd);
      end
   endtask

   always @(negedge clk) begin
      bit xr;
      bit xw;
      logic [31:0] xd;
      xr = (m_phase == RUN) && (m_q.size() < 32);
      xw = ((m_phase == RUN) && (m_q.size() >= 32)) || ((m_phase == FLUSH) && (m_q.size() > 0));
      xd = 32'd0;
      for (int i = 0; i < 32; i++) if (i < m_q.size()) xd[i] = m_q[i];
      if (chk_on) begin
         cmp_inst("a", 16, bus_a.pixel_ready, bus_a.RAM_write, bus_a.done, 32'(bus_a.word_count),
                  bus_a.overflow, 32'(bus_a.RAM_address), bus_a.RAM_writedata, xr, xw, xd, m_ovf16);
         cmp_inst("b", 4, bus_b.pixel_ready, bus_b.RAM_write, bus_b.done, 32'(bus_b.word_count),
                  bus_b.overflow, 32'(bus_b.RAM_address), bus_b.RAM_writedata, xr, xw, xd, m_ovf4);
      end
      rdy_s = bus_a.pixel_ready;
      if (bus_a.done) done_cnt++;
      if (bus_a.RAM_write && !wreq) begin
         cap_d.push_back(bus_a.RAM_writedata);
         cap_ad.push_back(int'(bus_a.RAM_address));
      end
      if (bus_b.RAM_write && !wreq) cap_ad4.push_back(int'(bus_b.RAM_address));
      if (rst) begin
         model_reset();
         chk_on = 1'b1;
      end else begin
         case (m_phase)
            RUN: begin
               if (xw && !wreq) model_write_done();
               if (xr && pvalid) model_push(color[23:0]);
               if (fe) m_phase = FLUSH;
            end
            FLUSH: begin
               if (m_q.size() == 0) begin
                  m_phase = DONE;
               end else if (xw && !wreq) begin
                  model_write_done();
                  if (m_q.size() == 0) m_phase = DONE;
               end
            end
            default: begin
               m_phase = RUN;
               m_addr  = 0;
               m_prev  = 24'd0;
               m_q.delete();
               m_nf    = 1'b1;
            end
         endcase
      end
   end

   // ---------------- directed stimulus ----------------
   function automatic logic [31:0] cap_at(input int i);
      return (i < cap_d.size()) ? cap_d[i] : 32'hDEADBEEF;
   endfunction

   function automatic int ad_at(input int i);
      return (i < cap_ad.size()) ? cap_ad[i] : -1;
   endfunction

   function automatic int ad4_at(input int i);
      return (i < cap_ad4.size()) ? cap_ad4[i] : -1;
   endfunction

   task automatic sync();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) sync();
   endtask

   task automatic send_pixel(input logic [31:0] c, input bit with_fe);
      int k;
      pvalid = 1'b1;
      color  = c;
      fe     = with_fe;
      for (k = 0; k < 100; k++) begin
         @(posedge clk);
         if (rdy_s) break;
      end
      #1;
      pvalid = 1'b0;
      fe     = 1'b0;
      check("pixel_accept_timeout", 32'(k < 100), 32'd1);
   endtask

   task automatic pulse_fe();
      fe = 1'b1;
      sync();
      fe = 1'b0;
   endtask

   task automatic wait_done(input string nm);
      int start;
      int k;
      start = done_cnt;
      for (k = 0; k < 200; k++) begin
         @(posedge clk);
         if (done_cnt != start) break;
      end
      #1;
      idle(3);
      check(nm, 32'(done_cnt - start), 32'd1);
   endtask

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   logic [23:0] t3_pix[9];

   initial begin : stim
      logic [63:0] stream;
      logic [23:0] dprev;
      logic [23:0] dpix;
      int          pos;
      int          dstart;

      idle(2);
      rst = 1'b0;
      @(negedge clk);
      check("rst_ready", 32'(bus_a.pixel_ready), 32'd1);
      check("rst_write", 32'(bus_a.RAM_write), 32'd0);
      check("rst_done", 32'(bus_a.done), 32'd0);
      check("rst_word_count", 32'(bus_a.word_count), 32'd0);
      check("rst_overflow", 32'(bus_b.overflow), 32'd0);
      sync();

      // T1: 32 repeats of black -> one all-zero word
      cap_d.delete(); cap_ad.delete(); cap_ad4.delete();
      for (int i = 0; i < 32; i++) send_pixel(32'h0000_0000, 1'b0);
      @(negedge clk);
      check("t1_latency_write", 32'(bus_a.RAM_write), 32'd1);
      sync();
      pulse_fe();
      wait_done("t1_done_once");
      check("t1_nwords", 32'(cap_d.size()), 32'd1);
      check("t1_addr", 32'(ad_at(0)), 32'd0);
      check("t1_data", cap_at(0), 32'h0000_0000);
      check("t1_word_count", 32'(bus_a.word_count), 32'd1);

      // T2: single literal with frame_end on the same cycle -> padded word
      cap_d.delete(); cap_ad.delete(); cap_ad4.delete();
      send_pixel(32'h00FF_0000, 1'b1);
      wait_done("t2_done_once");
      check("t2_nwords", 32'(cap_d.size()), 32'd1);
      check("t2_addr", 32'(ad_at(0)), 32'd0);
      check("t2_data", cap_at(0), 32'h01FE_0001);

      // T3: 57-bit stream over two words; upper color byte must be ignored
      cap_d.delete(); cap_ad.delete(); cap_ad4.delete();
      t3_pix[0] = 24'h123456;
      t3_pix[1] = 24'h123456;
      for (int i = 2; i < 9; i++) t3_pix[i] = 24'h000001;
      send_pixel(32'hAB12_3456, 1'b0);
      send_pixel(32'hCD12_3456, 1'b0);
      for (int i = 2; i < 9; i++) send_pixel({8'h5A, t3_pix[i]}, 1'b0);
      pulse_fe();
      wait_done("t3_done_once");
      check("t3_nwords", 32'(cap_d.size()), 32'd2);
      check("t3_addr0", 32'(ad_at(0)), 32'd0);
      check("t3_addr1", 32'(ad_at(1)), 32'd1);
      check("t3_data0", cap_at(0), 32'h0C24_68AD);
      check("t3_data1", cap_at(1), 32'h0000_0000);
      check("t3_word_count", 32'(bus_a.word_count), 32'd2);
      stream = {cap_at(1), cap_at(0)};
      pos    = 0;
      dprev  = 24'd0;
      for (int p = 0; p < 9; p++) begin
         if (stream[pos] == 1'b0) begin
            dpix = dprev;
            pos  = pos + 1;
         end else begin
            dpix = stream[pos+1 +: 24];
            pos  = pos + 25;
         end
         check("t3_decode_pixel", 32'(dpix), 32'(t3_pix[p]));
         dprev = dpix;
      end
      check("t3_decode_bits", 32'(pos), 32'd57);

      // T4: RAM stalls a pending write for 5 cycles
      cap_d.delete(); cap_ad.delete(); cap_ad4.delete();
      check("t4_word_count_kept", 32'(bus_a.word_count), 32'd2);
      wreq = 1'b1;
      send_pixel(32'h00AB_CDEF, 1'b0);
      send_pixel(32'h0001_0203, 1'b0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("t4_stall_write", 32'(bus_a.RAM_write), 32'd1);
         check("t4_stall_ready", 32'(bus_a.pixel_ready), 32'd0);
         check("t4_stall_addr", 32'(bus_a.RAM_address), 32'd0);
         check("t4_stall_data", bus_a.RAM_writedata, 32'h0F57_9BDF);
      end
      sync();
      wreq = 1'b0;
      pulse_fe();
      wait_done("t4_done_once");
      check("t4_nwords", 32'(cap_d.size()), 32'd2);
      check("t4_data0", cap_at(0), 32'h0F57_9BDF);
      check("t4_data1", cap_at(1), 32'h0000_0408);
      check("t4_addr1", 32'(ad_at(1)), 32'd1);

      // T6: 22 distinct literals = 550 bits = 17 full words + a partial one
      cap_d.delete(); cap_ad.delete(); cap_ad4.delete();
      for (int i = 0; i < 22; i++) send_pixel(32'(i + 1), 1'b0);
      pulse_fe();
      wait_done("t6_done_once");
      check("t6_nwords", 32'(cap_d.size()), 32'd18);
      check("t6_data0", cap_at(0), 32'h0A00_0003);
      check("t6_addr16_w16", 32'(ad_at(16)), 32'd16);
      check("t6_addr15_w4", 32'(ad4_at(15)), 32'd15);
      check("t6_addr16_w4", 32'(ad4_at(16)), 32'd0);
      check("t6_overflow_w4", 32'(bus_b.overflow), 32'd1);
      check("t6_overflow_w16", 32'(bus_a.overflow), 32'd0);
      check("t6_word_count_w16", 32'(bus_a.word_count), 32'd18);
      check("t6_word_count_w4", 32'(bus_b.word_count), 32'd2);

      // T5: reset in the middle of a stalled flush
      cap_d.delete(); cap_ad.delete(); cap_ad4.delete();
      wreq = 1'b1;
      send_pixel(32'h00AB_CDEF, 1'b0);
      send_pixel(32'h0001_0203, 1'b0);
      pulse_fe();
      idle(2);
      check("t5_overflow_sticky", 32'(bus_b.overflow), 32'd1);
      dstart = done_cnt;
      rst = 1'b1;
      sync();
      rst = 1'b0;
      @(negedge clk);
      check("t5_write_dropped", 32'(bus_a.RAM_write), 32'd0);
      check("t5_overflow_cleared", 32'(bus_b.overflow), 32'd0);
      sync();
      wreq = 1'b0;
      idle(10);
      check("t5_no_done", 32'(done_cnt - dstart), 32'd0);
      check("t5_no_words", 32'(cap_d.size()), 32'd0);
      send_pixel(32'h00FF_0000, 1'b1);
      wait_done("t5_next_done");
      check("t5_next_addr", 32'(ad_at(0)), 32'd0);
      check("t5_next_data", cap_at(0), 32'h01FE_0001);

      idle(2);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/huffman_chunk_encoder.md
HUFFMAN_CHUNK_ENCODER -- requirements
Module: huffman_chunk_encoder

Interface
REQ-001 Parameter: ADDR_W, default 16, RAM word-address width.
REQ-002 clk  in  1  single clock; all logic rising-edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 pixel_write_valid  in  1  color holds a pixel to encode this cycle.
REQ-005 pixel_ready  out  1  encoder accepts a pixel this cycle.
REQ-006 color  in  32  pixel; bits 23:0 are RGB; bits 31:24 are ignored.
REQ-007 frame_end  in  1  one-cycle pulse: flush the current frame.
REQ-008 RAM_address  out  ADDR_W  word address of the current write.
REQ-009 RAM_writedata  out  32  compressed word.
REQ-010 RAM_write  out  1  write request.
REQ-011 RAM_waitrequest  in  1  RAM stalls the write; all RAM_* outputs hold while it is high.
REQ-012 done  out  1  one-cycle pulse: frame fully written.
REQ-013 word_count  out  ADDR_W  words written in the current or last frame.
REQ-014 overflow  out  1  sticky: the address wrapped within a frame.

Function
REQ-015 Code per accepted pixel (24 bits = color[23:0]):
- '0' (1 bit) if the pixel equals the previous pixel.
- otherwise '1' followed by 24 color bits, LSB first (25 bits).
REQ-016 The previous pixel shall be 0x000000 at the start of every frame.
REQ-017 Bit packing: LSB-first into a 64-bit accumulator with a 6-bit fill count; the first code bit of a frame lands in bit 0 of word 0.
REQ-018 Pixel acceptance:
- pixel_ready = (state == RUN) && (fill < 32).
- A pixel is accepted when pixel_ready && pixel_write_valid.
- Maximum fill is 31 + 25 = 56; the accumulator shall never overflow.
REQ-019 RAM write, in state RUN:
- When fill >= 32: RAM_write = 1 and RAM_writedata = accumulator[31:0].
- A write completes on a cycle with RAM_write && !RAM_waitrequest.
- On completion: accumulator shifts right by 32, fill -= 32, RAM_address += 1, word_count += 1.
REQ-020 Latency: a word shall appear on RAM_write on the cycle after the pixel that completed it is accepted.
REQ-021 States: RUN, FLUSH, DONE.
- RUN -> FLUSH on frame_end.
- FLUSH -> DONE after the last write completes.
- DONE -> RUN unconditionally, after one cycle.
REQ-022 frame_end coinciding with an accepted pixel: the pixel shall be encoded first, then the flush proceeds.
REQ-023 FLUSH behaviour:
- Write all full words.
- If 0 < fill < 32, write one word with bits above fill zero-padded.
- If fill == 0, write nothing.
REQ-024 DONE behaviour:
- done = 1 for that cycle.
- word_count keeps the frame total until the first write of the next frame.
- RAM_address and the previous pixel reset to 0, and fill resets to 0, on DONE -> RUN.
REQ-025 Address arithmetic is modulo 2^ADDR_W; a wrap from all-ones to 0 within a frame shall set overflow.
- overflow is cleared only by rst.
REQ-026 frame_end outside RUN shall be ignored.
REQ-027 pixel_write_valid while pixel_ready = 0 shall have no effect; the source must hold the pixel.

Reset
REQ-028 On rst, the following shall take effect in the next cycle, with any in-flight write abandoned:
- state = RUN;
- fill = 0 and accumulator = 0;
- previous pixel = 0x000000;
- RAM_address = 0, word_count = 0;
- RAM_write = 0, done = 0, overflow = 0;
- pixel_ready = 1.

Verification
REQ-029 32 pixels of 0x000000, then frame_end -> one write, addr 0, data 0x00000000; done pulses once; word_count = 1.
REQ-030 Single pixel 0xFF0000, then frame_end -> one write, addr 0, data 0x01FE0001 (padded); done pulses once.
REQ-031 Pixels 0x123456, 0x123456, then 0x000001 ×7, then frame_end:
- Bit stream is 25 + 1 + 25 + 6 = 57 bits.
- Required: two words at addr 0 and addr 1, with word_count = 2.
- The bench shall decode both words back to the 9 input pixels.
REQ-032 RAM_waitrequest held high 5 cycles during a write:
- RAM_address and RAM_writedata stay stable throughout.
- pixel_ready = 0 while fill >= 32.
- No word is lost or duplicated.
REQ-033 rst asserted in the middle of FLUSH -> RAM_write = 0 next cycle, no done pulse, next frame starts at addr 0.
REQ-034 ADDR_W = 4, 17 full words of literals in one frame -> address wraps 15 -> 0 and overflow = 1 until rst.
